// File: rtl/ipe_pkg.sv
// Shared definitions for the interrupt nesting controller.
// Holds IRQ geometry, the idle priority value, the sequencer FSM states, the default vector
// table base and a one-hot helper.
package ipe_pkg;

    localparam int unsigned NUM_IRQ   = 8;
    localparam int unsigned IRQ_ID_W  = 3;
    localparam logic [IRQ_ID_W-1:0] PRIO_IDLE = 3'd7;
    localparam logic [31:0] VEC_BASE_DFLT = 32'h0000_1000;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_OFFER
    } state_e;

    function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        logic [NUM_IRQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/isr_priority_stack.sv
// LIFO of in-service priorities.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   push, pop      : push push_data / pop the top entry; both together = pop then push
//   push_data      : entry to push
//   top            : top entry, all ones when empty
//   depth          : occupancy 0..DEPTH
//   empty, full    : occupancy flags
module isr_priority_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [3:0]       depth,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic [3:0]       depth_q, depth_d;
    logic             pop_eff, push_eff;
    logic [3:0]       wr_idx;

    assign empty = (depth_q == 4'd0);
    assign full  = (depth_q == 4'(DEPTH));
    assign depth = depth_q;

    // A pop frees a slot, so a simultaneous push is allowed even when full.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign wr_idx   = pop_eff ? depth_q - 4'd1 : depth_q;

    always_comb begin
        depth_d = depth_q;
        if (pop_eff && !push_eff) begin
            depth_d = depth_q - 4'd1;
        end else if (push_eff && !pop_eff) begin
            depth_d = depth_q + 4'd1;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_d[i] = entries_q[i];
            if (push_eff && wr_idx == 4'(i)) begin
                entries_d[i] = push_data;
            end
        end
    end

    always_comb begin
        top = '1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (depth_q == 4'(i + 1)) begin
                top = entries_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= 4'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: rtl/isr_nest_controller.sv
// Sequencer between the interrupt priority encoder and the CPU.
// Latches encoder events into a sticky pending set, offers the most urgent eligible id to the
// CPU over a stable req/ack handshake and tracks nested ISRs on a priority stack.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   irq_valid, irq_id     : encoder event strobe and id
//   cpu_irq, cpu_irq_id   : offer to the CPU and offered id (stable while offered)
//   cpu_vector            : VEC_BASE + cpu_irq_id*4
//   cpu_ack, cpu_eoi      : CPU accepts offer / ends the top ISR
//   src_ack               : one-hot pulse of the accepted id
//   current_isr_priority  : top-of-stack priority, 7 when idle
//   isr_active, nest_depth: stack non-empty / occupancy
//   pending               : sticky pending set
//   eoi_err               : pulse on EOI with an empty stack
module isr_nest_controller
    import ipe_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DFLT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                irq_valid,
    input  logic [IRQ_ID_W-1:0] irq_id,
    output logic                cpu_irq,
    output logic [IRQ_ID_W-1:0] cpu_irq_id,
    output logic [31:0]         cpu_vector,
    input  logic                cpu_ack,
    input  logic                cpu_eoi,
    output logic [NUM_IRQ-1:0]  src_ack,
    output logic [IRQ_ID_W-1:0] current_isr_priority,
    output logic                isr_active,
    output logic [3:0]          nest_depth,
    output logic [NUM_IRQ-1:0]  pending,
    output logic                eoi_err
);

    state_e               state_q, state_d;
    logic [IRQ_ID_W-1:0]  id_q, id_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   src_ack_q;
    logic                 eoi_err_q;
    logic                 cooldown_q;
    logic                 accept;

    logic [IRQ_ID_W-1:0]  stk_top;
    logic [3:0]           stk_depth;
    logic                 stk_empty, stk_full;

    logic [NUM_IRQ-1:0]   eligible;
    logic                 cand_valid;
    logic [IRQ_ID_W-1:0]  cand_id;

    isr_priority_stack #(
        .DEPTH (DEPTH),
        .WIDTH (IRQ_ID_W)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .pop       (cpu_eoi),
        .push_data (id_q),
        .top       (stk_top),
        .depth     (stk_depth),
        .empty     (stk_empty),
        .full      (stk_full)
    );

    // Only ids strictly more urgent than the top are eligible, which also excludes every id
    // already in service since the stack is strictly decreasing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (pending_q[i] && !stk_full && (stk_empty || IRQ_ID_W'(i) < stk_top)) begin
                eligible[i] = 1'b1;
            end
        end
        cand_valid = |eligible;
        cand_id    = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_id = IRQ_ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // cooldown_q holds IDLE for one extra cycle after an accept
                if (cand_valid && !cooldown_q) begin
                    state_d = ST_OFFER;
                    id_d    = cand_id;
                end
            end
            ST_OFFER: begin
                if (cpu_ack) begin
                    state_d = ST_IDLE;
                    accept  = 1'b1;
                end
            end
        endcase
    end

    // Set wins over clear on the same id.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = pending_d & ~id_onehot(id_q);
        end
        if (irq_valid) begin
            pending_d = pending_d | id_onehot(irq_id);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            pending_q  <= '0;
            src_ack_q  <= '0;
            eoi_err_q  <= 1'b0;
            cooldown_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            pending_q  <= pending_d;
            src_ack_q  <= accept ? id_onehot(id_q) : '0;
            eoi_err_q  <= cpu_eoi && stk_empty;
            cooldown_q <= accept;
        end
    end

    assign cpu_irq              = (state_q == ST_OFFER);
    assign cpu_irq_id           = id_q;
    assign cpu_vector           = VEC_BASE + {27'b0, id_q, 2'b00};
    assign src_ack              = src_ack_q;
    assign current_isr_priority = stk_empty ? PRIO_IDLE : stk_top;
    assign isr_active           = !stk_empty;
    assign nest_depth           = stk_depth;
    assign pending              = pending_q;
    assign eoi_err              = eoi_err_q;

endmodule

// File: tb/tb_isr_nest_controller.sv
// Self-checking bench for isr_nest_controller (DEPTH=4, VEC_BASE=32'h1000).
module tb_isr_nest_controller;

    logic        clk;
    logic        reset_n;
    logic        irq_valid;
    logic [2:0]  irq_id;
    logic        cpu_irq;
    logic [2:0]  cpu_irq_id;
    logic [31:0] cpu_vector;
    logic        cpu_ack;
    logic        cpu_eoi;
    logic [7:0]  src_ack;
    logic [2:0]  current_isr_priority;
    logic        isr_active;
    logic [3:0]  nest_depth;
    logic [7:0]  pending;
    logic        eoi_err;

    int n_tests;
    int n_fail;

    isr_nest_controller #(
        .DEPTH    (4),
        .VEC_BASE (32'h0000_1000)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .irq_valid            (irq_valid),
        .irq_id               (irq_id),
        .cpu_irq              (cpu_irq),
        .cpu_irq_id           (cpu_irq_id),
        .cpu_vector           (cpu_vector),
        .cpu_ack              (cpu_ack),
        .cpu_eoi              (cpu_eoi),
        .src_ack              (src_ack),
        .current_isr_priority (current_isr_priority),
        .isr_active           (isr_active),
        .nest_depth           (nest_depth),
        .pending              (pending),
        .eoi_err              (eoi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  id;
        logic        ack;
        logic        eoi;
        logic        e_irq;
        logic [2:0]  e_id;
        logic [31:0] e_vec;
        logic [7:0]  e_src;
        logic [2:0]  e_prio;
        logic [3:0]  e_depth;
        logic [7:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are held across one rising edge, then cleared; outputs are read 1 unit later.
    task automatic step(input logic v, input logic [2:0] id, input logic ack, input logic eoi);
        irq_valid = v;
        irq_id    = id;
        cpu_ack   = ack;
        cpu_eoi   = eoi;
        @(posedge clk);
        #1;
        irq_valid = 1'b0;
        irq_id    = 3'd0;
        cpu_ack   = 1'b0;
        cpu_eoi   = 1'b0;
    endtask

    task automatic wait_offer(input logic [2:0] exp_id, input string name);
        int n;
        n = 0;
        while (!cpu_irq && n < 10) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            n++;
        end
        check(name, {60'd0, cpu_irq, cpu_irq_id}, {60'd0, 1'b1, exp_id});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [63:0] all_outs();
        return {3'd0, cpu_irq, cpu_irq_id, cpu_vector, src_ack, current_isr_priority,
                isr_active, nest_depth, pending, eoi_err};
    endfunction

    localparam logic [63:0] RESET_OUTS = {3'd0, 1'b0, 3'd0, 32'h0000_1000, 8'h00, 3'd7,
                                          1'b0, 4'd0, 8'h00, 1'b0};

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        irq_valid = 1'b0;
        irq_id    = 3'd0;
        cpu_ack   = 1'b0;
        cpu_eoi   = 1'b0;

        //        v  id    ack eoi  irq id    vec           src    prio  dep   pend   err
        tbl[0]  = '{1, 3'd5, 0, 0,  0, 3'd0, 32'h1000, 8'h00, 3'd7, 4'd0, 8'h20, 0};
        tbl[1]  = '{0, 3'd0, 0, 0,  1, 3'd5, 32'h1014, 8'h00, 3'd7, 4'd0, 8'h20, 0};
        tbl[2]  = '{0, 3'd0, 1, 0,  0, 3'd5, 32'h1014, 8'h20, 3'd5, 4'd1, 8'h00, 0};
        tbl[3]  = '{1, 3'd2, 0, 0,  0, 3'd5, 32'h1014, 8'h00, 3'd5, 4'd1, 8'h04, 0};
        tbl[4]  = '{0, 3'd0, 0, 0,  1, 3'd2, 32'h1008, 8'h00, 3'd5, 4'd1, 8'h04, 0};
        tbl[5]  = '{0, 3'd0, 1, 0,  0, 3'd2, 32'h1008, 8'h04, 3'd2, 4'd2, 8'h00, 0};
        tbl[6]  = '{1, 3'd4, 0, 0,  0, 3'd2, 32'h1008, 8'h00, 3'd2, 4'd2, 8'h10, 0};
        tbl[7]  = '{0, 3'd0, 0, 0,  0, 3'd2, 32'h1008, 8'h00, 3'd2, 4'd2, 8'h10, 0};
        tbl[8]  = '{0, 3'd0, 0, 1,  0, 3'd2, 32'h1008, 8'h00, 3'd5, 4'd1, 8'h10, 0};
        tbl[9]  = '{0, 3'd0, 0, 0,  1, 3'd4, 32'h1010, 8'h00, 3'd5, 4'd1, 8'h10, 0};
        tbl[10] = '{0, 3'd0, 1, 0,  0, 3'd4, 32'h1010, 8'h10, 3'd4, 4'd2, 8'h00, 0};
        tbl[11] = '{0, 3'd0, 0, 1,  0, 3'd4, 32'h1010, 8'h00, 3'd5, 4'd1, 8'h00, 0};
        tbl[12] = '{0, 3'd0, 0, 1,  0, 3'd4, 32'h1010, 8'h00, 3'd7, 4'd0, 8'h00, 0};
        tbl[13] = '{0, 3'd0, 0, 1,  0, 3'd4, 32'h1010, 8'h00, 3'd7, 4'd0, 8'h00, 1};
        tbl[14] = '{0, 3'd0, 0, 0,  0, 3'd4, 32'h1010, 8'h00, 3'd7, 4'd0, 8'h00, 0};

        // Reset state
        #12;
        check("reset_outputs", all_outs(), RESET_OUTS);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic offer / accept / nesting / EOI / empty-EOI vectors
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].id, tbl[i].ack, tbl[i].eoi);
            check($sformatf("vec%0d", i), all_outs(),
                  {3'd0, tbl[i].e_irq, tbl[i].e_id, tbl[i].e_vec, tbl[i].e_src, tbl[i].e_prio,
                   tbl[i].e_depth != 4'd0, tbl[i].e_depth, tbl[i].e_pend, tbl[i].e_err});
        end

        // Offer stays on id 3 while id 1 arrives; id 1 comes two edges after the ack
        do_reset();
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        check("offer3_up", {55'd0, cpu_irq, cpu_irq_id, pending}, {55'd0, 1'b1, 3'd3, 8'h0A});
        step(1'b0, 3'd0, 1'b0, 1'b0);
        check("offer3_stable", {60'd0, cpu_irq, cpu_irq_id}, {60'd0, 1'b1, 3'd3});
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("ack3", {48'd0, cpu_irq, src_ack, current_isr_priority, nest_depth},
              {48'd0, 1'b0, 8'h08, 3'd3, 4'd1});
        step(1'b0, 3'd0, 1'b0, 1'b0);
        check("holdoff_m1", {63'd0, cpu_irq}, {63'd0, 1'b0});
        step(1'b0, 3'd0, 1'b0, 1'b0);
        check("offer1_m2", {28'd0, cpu_irq, cpu_irq_id, cpu_vector},
              {28'd0, 1'b1, 3'd1, 32'h1004});

        // EOI and ack on the same edge at depth 2
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("depth2", {57'd0, current_isr_priority, nest_depth}, {57'd0, 3'd1, 4'd2});
        step(1'b1, 3'd0, 1'b0, 1'b0);
        wait_offer(3'd0, "offer0");
        step(1'b0, 3'd0, 1'b1, 1'b1);
        check("eoi_ack_same", {48'd0, src_ack, current_isr_priority, nest_depth, eoi_err},
              {48'd0, 8'h01, 3'd0, 4'd2, 1'b0});
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("pop_to_3", {57'd0, current_isr_priority, nest_depth}, {57'd0, 3'd3, 4'd1});

        // Full stack blocks even the most urgent id until one EOI
        do_reset();
        for (int k = 6; k >= 3; k--) begin
            step(1'b1, 3'(k), 1'b0, 1'b0);
            wait_offer(3'(k), $sformatf("nest_offer%0d", k));
            step(1'b0, 3'd0, 1'b1, 1'b0);
        end
        check("full", {56'd0, current_isr_priority, isr_active, nest_depth},
              {56'd0, 3'd3, 1'b1, 4'd4});
        step(1'b1, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
        end
        check("full_blocks", {55'd0, cpu_irq, pending}, {55'd0, 1'b0, 8'h01});
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("full_eoi", {56'd0, cpu_irq, current_isr_priority, nest_depth},
              {56'd0, 1'b0, 3'd4, 4'd3});
        step(1'b0, 3'd0, 1'b0, 1'b0);
        check("offer0_after_eoi", {28'd0, cpu_irq, cpu_irq_id, cpu_vector},
              {28'd0, 1'b1, 3'd0, 32'h1000});

        // Asynchronous reset mid-offer at depth 3 with a second request pending
        step(1'b1, 3'd2, 1'b0, 1'b0);
        check("pre_reset_pend", {56'd0, pending}, {56'd0, 8'h05});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", all_outs(), RESET_OUTS);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
        end
        check("post_reset_quiet", all_outs(), RESET_OUTS);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
